// File: rtl/hatch_pkg.sv
// Shared definitions for the incubation sequencer and the dot-matrix display driver:
// sequencer states, special picture codes and the stage-to-picture mapping.
package hatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INCUBATE,
        ST_WARN,
        ST_HATCHED,
        ST_FAILED
    } hatch_state_e;

    localparam logic [3:0] FRM_WARN  = 4'd8;
    localparam logic [3:0] FRM_CHICK = 4'd10;
    localparam logic [3:0] FRM_FAIL  = 4'd11;

    localparam logic [3:0] LAST_STAGE = 4'd9;

    // Picture 8 is reserved for the warning frame, so stages 8 and 9 shift up by one.
    function automatic logic [3:0] stage_frame(input logic [3:0] stage);
        logic [3:0] frame;
        if (stage >= LAST_STAGE) begin
            frame = FRM_CHICK;
        end else if (stage == 4'd8) begin
            frame = 4'd9;
        end else begin
            frame = stage;
        end
        return frame;
    endfunction

endpackage

// File: rtl/hatch_tick_gen.sv
// Seconds prescaler: counts clk cycles while enabled and pulses tick_o on the
// last cycle of each TICK_DIV-cycle period. clr_i restarts the period.
module hatch_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/hatch_seq.sv
// Egg incubation sequencer: runs the hatching timeline in 1 s ticks, supervises
// the temperature and drives picture index / temp flag / enable of the display driver.
module hatch_seq
    import hatch_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int STAGE_SEC = 3,
    parameter int FAIL_SEC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       temp_ok,
    output logic [3:0] num,
    output logic       temp,
    output logic       st,
    output logic       done,
    output logic       fail
);

    localparam int SW = (STAGE_SEC > 1) ? $clog2(STAGE_SEC) : 1;
    localparam int BW = (FAIL_SEC > 1) ? $clog2(FAIL_SEC) : 1;
    localparam logic [SW-1:0] SEC_LAST = SW'(STAGE_SEC - 1);
    localparam logic [BW-1:0] BAD_LAST = BW'(FAIL_SEC - 1);

    logic start_meta_q, start_sync_q, start_prev_q;
    logic temp_meta_q, temp_ok_s_q;
    logic start_edge;
    logic tick;
    logic clr_tick;

    hatch_state_e  state_q, state_d;
    logic [3:0]    stage_q, stage_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          blink_q, blink_d;
    logic [3:0]    num_q, num_d;
    logic          temp_q, temp_d;
    logic          st_q, st_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            temp_meta_q  <= 1'b0;
            temp_ok_s_q  <= 1'b0;
        end else begin
            start_meta_q <= start_btn;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
            temp_meta_q  <= temp_ok;
            temp_ok_s_q  <= temp_meta_q;
        end
    end

    assign start_edge = start_sync_q && !start_prev_q;

    hatch_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q != ST_IDLE),
        .clr_i (clr_tick),
        .tick_o(tick)
    );

    // Within a cycle: start_edge wins over a temperature change, which wins over tick.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        sec_d    = sec_q;
        bad_d    = bad_q;
        blink_d  = blink_q;
        clr_tick = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d  = ST_INCUBATE;
                    stage_d  = '0;
                    sec_d    = '0;
                    bad_d    = '0;
                    blink_d  = 1'b0;
                    clr_tick = 1'b1;
                end
            end
            ST_INCUBATE: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end else if (!temp_ok_s_q) begin
                    state_d = ST_WARN;
                    bad_d   = '0;
                    blink_d = 1'b1;
                end else if (tick) begin
                    if (sec_q == SEC_LAST) begin
                        if (stage_q == LAST_STAGE) begin
                            state_d = ST_HATCHED;
                        end else begin
                            sec_d   = '0;
                            stage_d = stage_q + 4'd1;
                        end
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end
            end
            ST_WARN: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end else if (temp_ok_s_q) begin
                    state_d = ST_INCUBATE;
                    bad_d   = '0;
                end else if (tick) begin
                    blink_d = !blink_q;
                    if (bad_q == BAD_LAST) begin
                        state_d = ST_FAILED;
                    end else begin
                        bad_d = bad_q + 1'b1;
                    end
                end
            end
            ST_HATCHED, ST_FAILED: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        num_d  = 4'd0;
        temp_d = 1'b1;
        st_d   = 1'b1;
        done_d = 1'b0;
        fail_d = 1'b0;
        case (state_d)
            ST_IDLE:     st_d = 1'b0;
            ST_INCUBATE: num_d = stage_frame(stage_d);
            ST_WARN: begin
                temp_d = 1'b0;
                num_d  = blink_d ? FRM_WARN : stage_frame(stage_d);
            end
            ST_HATCHED: begin
                num_d  = FRM_CHICK;
                done_d = 1'b1;
            end
            ST_FAILED: begin
                num_d  = FRM_FAIL;
                temp_d = 1'b0;
                fail_d = 1'b1;
            end
            default: st_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            sec_q   <= '0;
            bad_q   <= '0;
            blink_q <= 1'b0;
            num_q   <= 4'd0;
            temp_q  <= 1'b1;
            st_q    <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            sec_q   <= sec_d;
            bad_q   <= bad_d;
            blink_q <= blink_d;
            num_q   <= num_d;
            temp_q  <= temp_d;
            st_q    <= st_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    assign num  = num_q;
    assign temp = temp_q;
    assign st   = st_q;
    assign done = done_q;
    assign fail = fail_q;

endmodule
